// File: rtl/knn_pkg.sv
// Shared definitions for the knn point-stream blocks: state encoding,
// default problem sizes and the address-width helper.
package knn_pkg;

  localparam int NBR_TESTP_DEF = 4;
  localparam int NBR_DATAP_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_TPEND = 3'd4,
    S_DONE  = 3'd5
  } knn_state_e;

  // Address width for n entries, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_feeder_if.sv
// Point-stream bundle between the feeder (master) and knn_core (slave).
interface knn_feeder_if
  import knn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TADDR_W = clog2_min1(NBR_TESTP_DEF)
);
  logic               clear_list;
  logic               pt_valid;
  logic               pt_ready;
  logic [DATA_W-1:0]  pt_A;
  logic [DATA_W-1:0]  pt_B;
  logic               pt_last;
  logic               tp_done;
  logic [TADDR_W-1:0] tp_idx;

  modport master (
    output clear_list, pt_valid, pt_A, pt_B, pt_last, tp_done, tp_idx,
    input  pt_ready
  );

  modport slave (
    input  clear_list, pt_valid, pt_A, pt_B, pt_last, tp_done, tp_idx,
    output pt_ready
  );
endinterface

// File: rtl/knn_idx_cnt.sv
// Saturating index counter with synchronous clear, increment and at-max flag.
module knn_idx_cnt
  import knn_pkg::*;
#(
  parameter int MAX = NBR_TESTP_DEF,
  parameter int W   = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_IDX = W'(MAX - 1);

  logic [W-1:0] idx_r;

  // index register; clear wins over increment, never steps past MAX_IDX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {W{1'b0}};
    end else if (clr) begin
      idx_r <= {W{1'b0}};
    end else if (inc && (idx_r != MAX_IDX)) begin
      idx_r <= idx_r + W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx    = idx_r;
  assign at_max = (idx_r == MAX_IDX);

endmodule

// File: rtl/knn_feeder.sv
// Walks every (test point, data point) pair, fetches both coordinates from
// the point memories and streams them to the knn core with framing strobes.
module knn_feeder
  import knn_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NBR_TESTP = NBR_TESTP_DEF,
  parameter int NBR_DATAP = NBR_DATAP_DEF,
  parameter int TADDR_W   = clog2_min1(NBR_TESTP),
  parameter int DADDR_W   = clog2_min1(NBR_DATAP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [TADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0]  test_rdata,
  output logic [DADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0]  data_rdata,
  knn_feeder_if.master       pt
);

  knn_state_e         state_r, state_s;
  logic [TADDR_W-1:0] t_idx_s;
  logic [DADDR_W-1:0] d_idx_s;
  logic               t_max_s, d_max_s;
  logic               t_clr_s, t_inc_s, d_clr_s, d_inc_s;
  logic               capture_s;

  logic               busy_r, done_r, clear_r, valid_r, last_r, tpd_r;
  logic [TADDR_W-1:0] tpi_r;
  logic [DATA_W-1:0]  a_r, b_r;
  logic [DADDR_W-1:0] daddr_r;

  knn_idx_cnt #(.MAX(NBR_TESTP), .W(TADDR_W)) u_tcnt (
    .clk(clk), .rst_n(rst), .clr(t_clr_s), .inc(t_inc_s),
    .idx(t_idx_s), .at_max(t_max_s)
  );

  knn_idx_cnt #(.MAX(NBR_DATAP), .W(DADDR_W)) u_dcnt (
    .clk(clk), .rst_n(rst), .clr(d_clr_s), .inc(d_inc_s),
    .idx(d_idx_s), .at_max(d_max_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and index control; abort overrides every transition
  always_comb begin
    state_s = state_r;
    t_clr_s = 1'b0;
    t_inc_s = 1'b0;
    d_clr_s = 1'b0;
    d_inc_s = 1'b0;
    if (abort && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_s = S_CLEAR;
            t_clr_s = 1'b1;
            d_clr_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_CLEAR: state_s = S_FETCH;
        S_FETCH: state_s = S_SEND;
        S_SEND: begin
          if (pt.pt_ready && d_max_s) begin
            state_s = S_TPEND;
          end else if (pt.pt_ready) begin
            state_s = S_FETCH;
            d_inc_s = 1'b1;
          end else begin
            state_s = S_SEND;
          end
        end
        S_TPEND: begin
          if (t_max_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_CLEAR;
            t_inc_s = 1'b1;
            d_clr_s = 1'b1;
          end
        end
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  assign capture_s = (state_r == S_FETCH) && (state_s == S_SEND);

  // registered strobes, derived from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      clear_r <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      tpd_r   <= 1'b0;
      tpi_r   <= {TADDR_W{1'b0}};
    end else begin
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
      clear_r <= (state_s == S_CLEAR);
      valid_r <= (state_s == S_SEND);
      last_r  <= (state_s == S_SEND) && d_max_s;
      tpd_r   <= (state_s == S_TPEND);
      if ((state_r == S_SEND) && (state_s == S_TPEND)) begin
        tpi_r <= t_idx_s;
      end else begin
        tpi_r <= tpi_r;
      end
    end
  end

  // A/B capture and data address; during SEND the address already points at
  // the next data word so the 1-cycle read is ready when FETCH samples it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      daddr_r <= {DADDR_W{1'b0}};
    end else begin
      if (capture_s) begin
        a_r <= test_rdata;
        b_r <= data_rdata;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
      if (d_clr_s) begin
        daddr_r <= {DADDR_W{1'b0}};
      end else if (capture_s && !d_max_s) begin
        daddr_r <= d_idx_s + DADDR_W'(1);
      end else if (capture_s) begin
        daddr_r <= d_idx_s;
      end else begin
        daddr_r <= daddr_r;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign test_addr     = t_idx_s;
  assign data_addr     = daddr_r;
  assign pt.clear_list = clear_r;
  assign pt.pt_valid   = valid_r;
  assign pt.pt_A       = a_r;
  assign pt.pt_B       = b_r;
  assign pt.pt_last    = last_r;
  assign pt.tp_done    = tpd_r;
  assign pt.tp_idx     = tpi_r;

endmodule

// File: tb/tb_knn_feeder.sv
// Directed bench for knn_feeder: default-size runs, backpressure, a 1x1
// instance, abort, asynchronous reset and start filtering.
module tb_knn_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, busy, done;
  logic [1:0]  t_addr;
  logic [3:0]  d_addr;
  logic [31:0] t_rdata, d_rdata;

  logic        start_s, abort_s, busy_s, done_s;
  logic [0:0]  t_addr_s, d_addr_s;
  logic [31:0] t_rdata_s, d_rdata_s;

  int n_vec = 0;
  int n_err = 0;
  int pcount = 0;
  int base = 0;

  logic [31:0] hs_a[$];
  logic [31:0] hs_b[$];
  bit          hs_l[$];
  int          hs_c[$];
  int          clr_c[$];
  int          tp_q[$];
  int          done_c[$];

  knn_feeder_if #(.DATA_W(32), .TADDR_W(2)) pt_m ();
  knn_feeder_if #(.DATA_W(32), .TADDR_W(1)) pt_s ();

  knn_feeder #(.DATA_W(32), .NBR_TESTP(4), .NBR_DATAP(10)) u_dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .test_addr(t_addr), .test_rdata(t_rdata),
    .data_addr(d_addr), .data_rdata(d_rdata),
    .pt(pt_m.master)
  );

  knn_feeder #(.DATA_W(32), .NBR_TESTP(1), .NBR_DATAP(1)) u_small (
    .clk(clk), .rst(rst_n), .start(start_s), .abort(abort_s),
    .busy(busy_s), .done(done_s),
    .test_addr(t_addr_s), .test_rdata(t_rdata_s),
    .data_addr(d_addr_s), .data_rdata(d_rdata_s),
    .pt(pt_s.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcount <= pcount + 1;

  // synchronous-read point memories: test[i]=i+1, data[j]=100+j
  always @(posedge clk) begin
    t_rdata   <= 32'(t_addr) + 32'd1;
    d_rdata   <= 32'(d_addr) + 32'd100;
    t_rdata_s <= (t_addr_s == 1'b0) ? 32'h0000_00AA : 32'h0;
    d_rdata_s <= (d_addr_s == 1'b0) ? 32'h0000_00BB : 32'h0;
  end

  // event log of the main instance, sampled mid-cycle
  always @(negedge clk) begin
    if (pt_m.pt_valid && pt_m.pt_ready) begin
      hs_a.push_back(pt_m.pt_A);
      hs_b.push_back(pt_m.pt_B);
      hs_l.push_back(pt_m.pt_last);
      hs_c.push_back(pcount - base);
    end
    if (pt_m.clear_list) clr_c.push_back(pcount - base);
    if (pt_m.tp_done) tp_q.push_back(int'(pt_m.tp_idx));
    if (done) done_c.push_back(pcount - base);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap(output int s_hs, output int s_clr, output int s_tp, output int s_done);
    s_hs   = hs_a.size();
    s_clr  = clr_c.size();
    s_tp   = tp_q.size();
    s_done = done_c.size();
  endtask

  task automatic verify_run(input string tag, input int s_hs, input int s_clr,
                            input int s_tp, input int s_done, input int exp_done);
    int n;
    int nt;
    int nd;
    n = hs_a.size() - s_hs;
    chk({tag, "_pairs"}, 32'(n), 32'd40);
    for (int k = 0; k < n && k < 40; k++) begin
      chk({tag, "_A"}, hs_a[s_hs+k], 32'(k / 10 + 1));
      chk({tag, "_B"}, hs_b[s_hs+k], 32'(100 + k % 10));
      chk({tag, "_last"}, 32'(hs_l[s_hs+k]), (k % 10 == 9) ? 32'd1 : 32'd0);
    end
    if (n > 0) chk({tag, "_first_valid_cyc"}, 32'(hs_c[s_hs]), 32'd3);
    chk({tag, "_clear_cnt"}, 32'(clr_c.size() - s_clr), 32'd4);
    if (clr_c.size() > s_clr) chk({tag, "_first_clear_cyc"}, 32'(clr_c[s_clr]), 32'd1);
    nt = tp_q.size() - s_tp;
    chk({tag, "_tp_done_cnt"}, 32'(nt), 32'd4);
    for (int k = 0; k < nt && k < 4; k++) chk({tag, "_tp_idx"}, 32'(tp_q[s_tp+k]), 32'(k));
    nd = done_c.size() - s_done;
    chk({tag, "_done_cnt"}, 32'(nd), 32'd1);
    if (nd > 0) chk({tag, "_done_cyc"}, 32'(done_c[s_done]), 32'(exp_done));
  endtask

  task automatic run_main(input int stall_n, input bit with_abort, input int poke_start_at,
                          input int budget);
    int  s_done;
    int  s_hs;
    int  left;
    int  cyc;
    bit  stalling;
    s_done   = done_c.size();
    s_hs     = hs_a.size();
    left     = stall_n;
    stalling = 1'b0;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    base  = pcount;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    cyc   = 1;
    while (done_c.size() == s_done && cyc < budget) begin
      start = (cyc == poke_start_at);
      if (!stalling && left > 0 && pt_m.pt_valid && (hs_a.size() - s_hs) == 14) stalling = 1'b1;
      if (stalling && left > 0) begin
        pt_m.pt_ready = 1'b0;
        left--;
        chk("stall_valid", 32'(pt_m.pt_valid), 32'd1);
        chk("stall_A", pt_m.pt_A, 32'd2);
        chk("stall_B", pt_m.pt_B, 32'd104);
        chk("stall_last", 32'(pt_m.pt_last), 32'd0);
      end else begin
        pt_m.pt_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    pt_m.pt_ready = 1'b1;
    chk("run_timeout", 32'(done_c.size() > s_done), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  logic [5:0] small_tab [1:6];

  initial begin
    int  s_hs, s_clr, s_tp, s_done;
    int  cyc;
    bit  aborted;
    small_tab[1] = 6'b110000;
    small_tab[2] = 6'b100000;
    small_tab[3] = 6'b101100;
    small_tab[4] = 6'b100010;
    small_tab[5] = 6'b100001;
    small_tab[6] = 6'b000000;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_s = 1'b0; abort_s = 1'b0;
    pt_m.pt_ready = 1'b1;
    pt_s.pt_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(pt_m.pt_valid), 32'd0);
    chk("rst_clear", 32'(pt_m.clear_list), 32'd0);
    chk("rst_A", pt_m.pt_A, 32'd0);
    chk("rst_taddr", 32'(t_addr), 32'd0);
    chk("rst_daddr", 32'(d_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal run
    snap(s_hs, s_clr, s_tp, s_done);
    run_main(0, 1'b0, -1, 300);
    verify_run("basic", s_hs, s_clr, s_tp, s_done, 89);

    // five stall cycles on pair (tp=1, j=4)
    snap(s_hs, s_clr, s_tp, s_done);
    run_main(5, 1'b0, -1, 300);
    verify_run("stall", s_hs, s_clr, s_tp, s_done, 94);

    // 1x1 instance, cycle by cycle
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("small_c%0d", c),
          32'({busy_s, pt_s.clear_list, pt_s.pt_valid, pt_s.pt_last, pt_s.tp_done, done_s}),
          32'(small_tab[c]));
      if (c == 3) begin
        chk("small_A", pt_s.pt_A, 32'h0000_00AA);
        chk("small_B", pt_s.pt_B, 32'h0000_00BB);
      end
      if (c == 4) chk("small_tp_idx", 32'(pt_s.tp_idx), 32'd0);
      @(posedge clk); #1;
    end

    // abort during a stalled SEND of pair (tp=2, j=3)
    snap(s_hs, s_clr, s_tp, s_done);
    @(negedge clk);
    start = 1'b1;
    base  = pcount;
    @(posedge clk); #1;
    start   = 1'b0;
    cyc     = 1;
    aborted = 1'b0;
    while (!aborted && cyc < 200) begin
      if ((hs_a.size() - s_hs) == 23 && pt_m.pt_valid) begin
        pt_m.pt_ready = 1'b0;
        abort = 1'b1;
        chk("abort_pair_A", pt_m.pt_A, 32'd3);
        chk("abort_pair_B", pt_m.pt_B, 32'd103);
        aborted = 1'b1;
      end else begin
        pt_m.pt_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
    pt_m.pt_ready = 1'b1;
    chk("abort_reached", 32'(aborted), 32'd1);
    chk("abort_valid", 32'(pt_m.pt_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (30) @(posedge clk); #1;
    chk("abort_pairs", 32'(hs_a.size() - s_hs), 32'd23);
    chk("abort_tp_done", 32'(tp_q.size() - s_tp), 32'd2);
    chk("abort_done", 32'(done_c.size() - s_done), 32'd0);
    snap(s_hs, s_clr, s_tp, s_done);
    run_main(0, 1'b0, -1, 300);
    verify_run("restart", s_hs, s_clr, s_tp, s_done, 89);

    // asynchronous reset in the FETCH of pair (tp=1, j=1)
    @(negedge clk);
    start = 1'b1;
    base  = pcount;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #3;
    chk("prerst_busy", 32'(busy), 32'd1);
    chk("prerst_taddr", 32'(t_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_taddr", 32'(t_addr), 32'd0);
    chk("arst_daddr", 32'(d_addr), 32'd0);
    chk("arst_A", pt_m.pt_A, 32'd0);
    chk("arst_B", pt_m.pt_B, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap(s_hs, s_clr, s_tp, s_done);
    run_main(0, 1'b0, -1, 300);
    verify_run("post_rst", s_hs, s_clr, s_tp, s_done, 89);

    // start+abort together in IDLE, then a stray start while busy
    snap(s_hs, s_clr, s_tp, s_done);
    run_main(0, 1'b1, 30, 300);
    repeat (6) @(posedge clk);
    verify_run("start_filter", s_hs, s_clr, s_tp, s_done, 89);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/knn_feeder.md
Name: knn_feeder

Overview:
- Initiator side of the knn point-stream interface.
- Walks every (test point, data point) pair, NBR_TESTP x NBR_DATAP in total.
- Fetches each coordinate word from two synchronous-read point memories and presents the pair as A/B with a valid/ready handshake to the knn datapath (distance + k-nearest list).
- Frames each test point: a list-clear pulse before its first pair, and a test-point-done pulse with its index after its last pair.
- Sits between the register/memory front end and knn_core.

Parameters:
- DATA_W, 32, width of one coordinate word (A/B).
- NBR_TESTP, 4, number of test points per run (>=1).
- NBR_DATAP, 10, number of data points per test point (>=1).
- TADDR_W, $clog2(NBR_TESTP) (min 1), test memory address width.
- DADDR_W, $clog2(NBR_DATAP) (min 1), data memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE next cycle.
- busy  out  1  high from the cycle after start is accepted until DONE, inclusive.
- done  out  1  one-cycle pulse at end of a completed run.
- test_addr  out  TADDR_W  test memory address (equals the current test index).
- test_rdata  in  DATA_W  test memory data, 1-cycle read latency.
- data_addr  out  DADDR_W  data memory address.
- data_rdata  in  DATA_W  data memory data, 1-cycle read latency.
- clear_list  out  1  one-cycle pulse; core clears its distance list and accumulator.
- pt_valid  out  1  A/B pair valid.
- pt_ready  in  1  core accepts the pair.
- pt_A  out  DATA_W  test point coordinate.
- pt_B  out  DATA_W  data point coordinate.
- pt_last  out  1  qualifies pt_valid: this pair is the last one for the current test point.
- tp_done  out  1  one-cycle pulse after the last pair of a test point is accepted.
- tp_idx  out  TADDR_W  index of the current test point; valid with tp_done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output 0, including both indices and pt_A/pt_B.
- All outputs are registered.
- States: IDLE, CLEAR, FETCH, SEND, TPEND, DONE.
- IDLE: busy=0. On start=1, go to CLEAR with test idx=0 and data idx=0. start is ignored in every other state.
- CLEAR (1 cycle): clear_list=1; test_addr/data_addr already show the current indices. Next state FETCH.
- FETCH (1 cycle): addresses stable. At the end of the cycle, capture test_rdata->pt_A and data_rdata->pt_B. Next state SEND.
- SEND:
  - pt_valid=1; pt_last=1 when data idx == NBR_DATAP-1.
  - pt_A, pt_B, pt_last hold stable while pt_valid && !pt_ready.
  - On pt_ready: if not last, data idx++ and go to FETCH; if last, go to TPEND.
  - pt_valid drops in the cycle after the handshake.
- TPEND (1 cycle): tp_done=1, tp_idx=current test idx.
  - If test idx == NBR_TESTP-1, go to DONE.
  - Else test idx++, data idx=0, go to CLEAR.
- DONE (1 cycle): done=1, busy=1. Next state IDLE with busy=0. Indices are not reset in DONE; they reset on the next accepted start.
- Indices never wrap past NBR_*-1; the state machine guarantees this.
- Cycle counts, with pt_ready tied high and start sampled in cycle 0:
  - Each pair costs 2 cycles (FETCH + SEND).
  - Each test point costs 2*NBR_DATAP+2 cycles.
  - First pt_valid is in cycle 3.
  - done is high in cycle 1+NBR_TESTP*(2*NBR_DATAP+2); with defaults this is cycle 89.
- Backpressure: each cycle with pt_ready=0 in SEND adds exactly one cycle. No pair is dropped or duplicated.
- abort=1 in any non-IDLE state: next cycle state=IDLE and all strobes 0. No done and no tp_done are issued. abort has priority over every other transition. abort in IDLE has no effect.
- abort and start both high in IDLE: start wins.
- rst asserted mid-run: immediate return to reset values. The core must be cleared by the next run's CLEAR.
- Degenerate sizes:
  - NBR_DATAP=1: pt_last is high on every pair.
  - NBR_TESTP=1: TPEND goes directly to DONE.

Decomposition:
- Shared package knn_pkg holds:
  - state encoding localparams (IDLE..DONE, 3 bits);
  - the clog2-with-minimum-1 width helper;
  - default NBR_TESTP/NBR_DATAP, shared with knn_core.
- One sub-module, knn_idx_cnt: a parameterised index counter with clear, increment and at-max flag. It is instantiated twice (test index and data index).
- The state machine and the A/B capture registers stay in knn_feeder.

Test Plan:
- Defaults, pt_ready=1, test mem[i]=i+1, data mem[j]=100+j, start pulse in cycle 0:
  - first pt_valid in cycle 3 with A=1, B=100;
  - 40 handshakes total; pt_last on pairs j=9;
  - tp_done x4 with tp_idx 0,1,2,3;
  - done in cycle 89 only.
- pt_ready low for 5 cycles on pair (tp=1, j=4):
  - pt_valid, A=2, B=104 and pt_last=0 all held;
  - done shifts to cycle 94;
  - no pair is duplicated or lost (scoreboard).
- NBR_TESTP=1, NBR_DATAP=1:
  - CLEAR, FETCH, SEND with pt_last=1, TPEND with tp_idx=0, then done in cycle 5.
- abort during SEND of pair (tp=2, j=3) while pt_ready=0:
  - next cycle state=IDLE, pt_valid=0, busy=0;
  - no tp_done for tp 2 and no done.
  - A following start restarts at tp=0, j=0, with clear_list in cycle 1.
- rst low mid-FETCH, asynchronously between clock edges:
  - all outputs 0 immediately, without waiting for an edge.
  - After release, start behaves as in the first scenario.
- start pulsed again while busy, and start+abort together in IDLE:
  - start while busy is ignored (the done count stays 1);
  - start+abort in IDLE starts a run.
